stm32_bus_engine: RTL and testbench

Parametrised byte-wide command engine between the STM32 parallel bus and the DDC/DUC fabric. It replaces fixed-layout parameter and IQ transfers with a generic parameter register file, a generic status readback and an N-channel RX IQ stream. The stream adds a per-frame header and XOR checksum. It sits between the top-level DATA_BUS pins and the RX FIFO, TX chain and configuration consumers.

---
 rtl/stm32_bus_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_stm32_bus_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stm32_bus_engine.sv
// Byte-wide command engine between the STM32 parallel bus and the DDC/DUC fabric.
// It provides a parameter register file, a status readback, TX IQ loading and a framed N-channel RX IQ stream.
module stm32_bus_engine #(
    parameter int unsigned NUM_RX       = 2,
    parameter int unsigned IQ_WIDTH     = 24,
    parameter int unsigned PARAM_BYTES  = 24,
    parameter int unsigned STATUS_BYTES = 12,
    parameter logic [PARAM_BYTES*8-1:0] PARAM_RESET = '0
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         DATA_SYNC,
    inout  wire  [7:0]                   DATA_BUS,
    output logic                         DATA_BUS_OE,
    input  logic [NUM_RX*IQ_WIDTH-1:0]   rx_i,
    input  logic [NUM_RX*IQ_WIDTH-1:0]   rx_q,
    input  logic                         iq_empty,
    output logic                         iq_rd_req,
    output logic [IQ_WIDTH-1:0]          tx_i,
    output logic [IQ_WIDTH-1:0]          tx_q,
    output logic                         tx_iq_valid,
    output logic [PARAM_BYTES*8-1:0]     param_regs,
    output logic                         param_update,
    output logic [NUM_RX-1:0]            rx_enable,
    input  logic [STATUS_BYTES*8-1:0]    status_in,
    output logic [3:0]                   stage_debug
);
    localparam int unsigned BPS    = IQ_WIDTH / 8;
    localparam int unsigned SW     = 2 * IQ_WIDTH;
    localparam int unsigned PW     = PARAM_BYTES * 8;
    localparam int unsigned STW    = STATUS_BYTES * 8;
    localparam int unsigned RXW    = NUM_RX * IQ_WIDTH;
    localparam int unsigned CH_W   = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
    localparam int unsigned BIDX_W = $clog2(BPS);
    localparam int unsigned CNT_W  = $clog2(PARAM_BYTES + STATUS_BYTES + 2 * BPS + 2);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ECHO   = 4'd1,
        S_PARAM  = 4'd2,
        S_STATUS = 4'd3,
        S_TXIQ   = 4'd4,
        S_RX     = 4'd5
    } state_t;

    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_CSUM} rx_stage_t;

    state_t             state_q, state_d;
    rx_stage_t          rx_stage_q, rx_stage_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               oe_q, oe_d;
    logic [7:0]         dout_q, dout_d;
    logic               rd_req_q, rd_req_d;
    logic [IQ_WIDTH-1:0] tx_i_q, tx_i_d, tx_q_q, tx_q_d;
    logic               tx_valid_q, tx_valid_d;
    logic [SW-1:0]      tx_sh_q, tx_sh_d;
    logic [PW-1:0]      shadow_q, shadow_d, param_q, param_d;
    logic               param_upd_q, param_upd_d;
    logic               copy_pend_q, copy_pend_d;
    logic [STW-1:0]     snap_q, snap_d;
    logic               underrun_q, underrun_d;
    logic               echo_ph_q, echo_ph_d;
    logic [RXW-1:0]     lat_i_q, lat_i_d, lat_q_q, lat_q_d;
    logic [NUM_RX-1:0]  mask_q, mask_d;
    logic [7:0]         csum_q, csum_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               part_q, part_d;
    logic [BIDX_W-1:0]  bidx_q, bidx_d;

    logic [IQ_WIDTH-1:0] cur_sample, cur_sh;
    logic [7:0]          cur_byte, hdr;
    logic [CH_W:0]       hit;

    // Lowest enabled channel at or above 'from'; MSB flags a hit.
    function automatic logic [CH_W:0] next_ch(input logic [NUM_RX-1:0] m, input int from);
        logic [CH_W:0]     r;
        logic [NUM_RX-1:0] t;
        r = '0;
        for (int i = int'(NUM_RX) - 1; i >= 0; i--) begin
            t = m >> i;
            if (t[0] && i >= from) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // Host owns the bus during the command strobe.
    assign DATA_BUS     = (oe_q && !DATA_SYNC) ? dout_q : 8'bz;
    assign DATA_BUS_OE  = oe_q;
    assign iq_rd_req    = rd_req_q;
    assign tx_i         = tx_i_q;
    assign tx_q         = tx_q_q;
    assign tx_iq_valid  = tx_valid_q;
    assign param_regs   = param_q;
    assign param_update = param_upd_q;
    assign rx_enable    = param_q[PW-8 +: NUM_RX];
    assign stage_debug  = state_q;

    always_comb begin
        cur_sample = part_q ? IQ_WIDTH'(lat_i_q >> (IQ_WIDTH * ch_q))
                            : IQ_WIDTH'(lat_q_q >> (IQ_WIDTH * ch_q));
        cur_sh     = cur_sample << (8 * bidx_q);
        cur_byte   = cur_sh[IQ_WIDTH-1 -: 8];
    end

    always_comb begin
        state_d     = state_q;
        rx_stage_d  = rx_stage_q;
        cnt_d       = cnt_q;
        oe_d        = oe_q;
        dout_d      = dout_q;
        rd_req_d    = 1'b0;
        tx_i_d      = tx_i_q;
        tx_q_d      = tx_q_q;
        tx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        shadow_d    = shadow_q;
        param_d     = param_q;
        param_upd_d = 1'b0;
        copy_pend_d = 1'b0;
        snap_d      = snap_q;
        underrun_d  = underrun_q;
        echo_ph_d   = echo_ph_q;
        lat_i_d     = lat_i_q;
        lat_q_d     = lat_q_q;
        mask_d      = mask_q;
        csum_d      = csum_q;
        ch_d        = ch_q;
        part_d      = part_q;
        bidx_d      = bidx_q;
        hdr         = '0;
        hit         = '0;

        if (copy_pend_q) begin
            param_d     = shadow_q;
            param_upd_d = 1'b1;
        end

        if (DATA_SYNC) begin
            cnt_d      = '0;
            echo_ph_d  = 1'b0;
            rx_stage_d = RX_HDR;
            oe_d       = 1'b0;
            case (DATA_BUS)
                8'd0: state_d = S_ECHO;
                8'd1: state_d = S_PARAM;
                8'd2: begin state_d = S_STATUS; oe_d = 1'b1; snap_d = status_in; end
                8'd3: state_d = S_TXIQ;
                8'd4: begin state_d = S_RX; oe_d = 1'b1; rd_req_d = 1'b1; end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_ECHO: begin
                    echo_ph_d = ~echo_ph_q;
                    oe_d      = ~echo_ph_q;
                    if (!echo_ph_q) dout_d = DATA_BUS;
                end
                S_PARAM: begin
                    shadow_d = {shadow_q[PW-9:0], DATA_BUS};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PARAM_BYTES - 1)) begin
                        copy_pend_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_STATUS: begin
                    if (cnt_q == '0) begin
                        dout_d     = {6'b0, underrun_q, iq_empty};
                        underrun_d = 1'b0;
                        cnt_d      = CNT_W'(1);
                    end else if (cnt_q <= CNT_W'(STATUS_BYTES)) begin
                        dout_d = snap_q[STW-1 -: 8];
                        snap_d = snap_q << 8;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_TXIQ: begin
                    tx_sh_d = {tx_sh_q[SW-9:0], DATA_BUS};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(2 * BPS - 1)) begin
                        tx_q_d     = tx_sh_d[SW-1 -: IQ_WIDTH];
                        tx_i_d     = tx_sh_d[IQ_WIDTH-1:0];
                        tx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_RX: begin
                    case (rx_stage_q)
                        RX_HDR: begin
                            lat_i_d    = rx_i;
                            lat_q_d    = rx_q;
                            mask_d     = rx_enable;
                            underrun_d = underrun_q | iq_empty;
                            hdr        = {6'b0, underrun_q | iq_empty, ~iq_empty};
                            dout_d     = hdr;
                            csum_d     = hdr;
                            hit        = next_ch(rx_enable, 0);
                            ch_d       = hit[CH_W-1:0];
                            part_d     = 1'b0;
                            bidx_d     = '0;
                            rx_stage_d = hit[CH_W] ? RX_DATA : RX_CSUM;
                        end
                        RX_DATA: begin
                            dout_d = cur_byte;
                            csum_d = csum_q ^ cur_byte;
                            bidx_d = bidx_q + BIDX_W'(1);
                            if (bidx_q == BIDX_W'(BPS - 1)) begin
                                bidx_d = '0;
                                part_d = ~part_q;
                                if (part_q) begin
                                    hit  = next_ch(mask_q, int'(ch_q) + 1);
                                    ch_d = hit[CH_W-1:0];
                                    if (!hit[CH_W]) rx_stage_d = RX_CSUM;
                                end
                            end
                        end
                        default: begin
                            // Checksum slot doubles as the fetch for the next frame.
                            dout_d     = csum_q;
                            rd_req_d   = 1'b1;
                            rx_stage_d = RX_HDR;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_stage_q  <= RX_HDR;
            cnt_q       <= '0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            rd_req_q    <= 1'b0;
            tx_i_q      <= '0;
            tx_q_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_sh_q     <= '0;
            shadow_q    <= '0;
            param_q     <= PARAM_RESET;
            param_upd_q <= 1'b0;
            copy_pend_q <= 1'b0;
            snap_q      <= '0;
            underrun_q  <= 1'b0;
            echo_ph_q   <= 1'b0;
            lat_i_q     <= '0;
            lat_q_q     <= '0;
            mask_q      <= '0;
            csum_q      <= '0;
            ch_q        <= '0;
            part_q      <= 1'b0;
            bidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            rx_stage_q  <= rx_stage_d;
            cnt_q       <= cnt_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            rd_req_q    <= rd_req_d;
            tx_i_q      <= tx_i_d;
            tx_q_q      <= tx_q_d;
            tx_valid_q  <= tx_valid_d;
            tx_sh_q     <= tx_sh_d;
            shadow_q    <= shadow_d;
            param_q     <= param_d;
            param_upd_q <= param_upd_d;
            copy_pend_q <= copy_pend_d;
            snap_q      <= snap_d;
            underrun_q  <= underrun_d;
            echo_ph_q   <= echo_ph_d;
            lat_i_q     <= lat_i_d;
            lat_q_q     <= lat_q_d;
            mask_q      <= mask_d;
            csum_q      <= csum_d;
            ch_q        <= ch_d;
            part_q      <= part_d;
            bidx_q      <= bidx_d;
        end
    end
endmodule

// File: tb/tb_stm32_bus_engine.sv
// Directed bench for stm32_bus_engine: every command phase, aborts, the RX frame layout and async reset.
module tb_stm32_bus_engine;
    logic         clk_in;
    logic         reset;
    logic         DATA_SYNC;
    wire  [7:0]   DATA_BUS;
    logic         DATA_BUS_OE;
    logic [47:0]  rx_i, rx_q;
    logic         iq_empty;
    logic         iq_rd_req;
    logic [23:0]  tx_i, tx_q;
    logic         tx_iq_valid;
    logic [191:0] param_regs;
    logic         param_update;
    logic [1:0]   rx_enable;
    logic [95:0]  status_in;
    logic [3:0]   stage_debug;

    logic [7:0]   hdrv;
    logic         hoe;
    int           n_cmp;
    int           n_err;
    logic [7:0]   fr [14];
    logic [191:0] p_first;

    assign DATA_BUS = hoe ? hdrv : 8'bz;

    stm32_bus_engine dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .DATA_SYNC   (DATA_SYNC),
        .DATA_BUS    (DATA_BUS),
        .DATA_BUS_OE (DATA_BUS_OE),
        .rx_i        (rx_i),
        .rx_q        (rx_q),
        .iq_empty    (iq_empty),
        .iq_rd_req   (iq_rd_req),
        .tx_i        (tx_i),
        .tx_q        (tx_q),
        .tx_iq_valid (tx_iq_valid),
        .param_regs  (param_regs),
        .param_update(param_update),
        .rx_enable   (rx_enable),
        .status_in   (status_in),
        .stage_debug (stage_debug)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [7:0] code);
        DATA_SYNC = 1'b1;
        hoe       = 1'b1;
        hdrv      = code;
        tick();
        DATA_SYNC = 1'b0;
        hoe       = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        hoe  = 1'b1;
        hdrv = b;
        tick();
        hoe  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        DATA_SYNC = 1'b0;
        hoe       = 1'b0;
        hdrv      = 8'h00;
        rx_i      = '0;
        rx_q      = '0;
        iq_empty  = 1'b0;
        status_in = 96'hC0C1C2C3C4C5C6C7C8C9CACB;
        p_first   = 192'h0102030405060708090a0b0c0d0e0f101112131415161718;

        tick();
        tick();
        chk("rst_oe", 256'(DATA_BUS_OE), 256'(1'b0));
        chk("rst_stage", 256'(stage_debug), 256'(4'd0));
        chk("rst_params", 256'(param_regs), 256'(192'h0));
        chk("rst_rdreq", 256'(iq_rd_req), 256'(1'b0));
        chk("rst_tx", 256'({tx_iq_valid, tx_i, tx_q}), 256'(49'h0));
        chk("rst_pupd", 256'(param_update), 256'(1'b0));
        reset = 1'b0;
        tick();

        // Full parameter write 0x01..0x18.
        cmd(8'd1);
        chk("pw_stage", 256'(stage_debug), 256'(4'd2));
        for (int i = 1; i <= 24; i++) wr_byte(8'(i));
        chk("pw_upd_early", 256'(param_update), 256'(1'b0));
        chk("pw_idle", 256'(stage_debug), 256'(4'd0));
        tick();
        chk("pw_upd", 256'(param_update), 256'(1'b1));
        chk("pw_regs", 256'(param_regs), 256'(p_first));
        chk("pw_rxen", 256'(rx_enable), 256'(2'b01));
        tick();
        chk("pw_upd_end", 256'(param_update), 256'(1'b0));

        // Aborted after 10 bytes by a TX_IQ command.
        cmd(8'd1);
        for (int i = 0; i < 10; i++) wr_byte(8'hEE);
        cmd(8'd3);
        chk("pab_upd", 256'(param_update), 256'(1'b0));
        chk("pab_stage", 256'(stage_debug), 256'(4'd4));
        tick();
        chk("pab_upd2", 256'(param_update), 256'(1'b0));
        chk("pab_regs", 256'(param_regs), 256'(p_first));

        // TX_IQ: that tick above consumed slot 0 with an idle bus, so restart cleanly.
        cmd(8'd3);
        wr_byte(8'h12); wr_byte(8'h34); wr_byte(8'h56);
        wr_byte(8'hAB); wr_byte(8'hCD);
        chk("tx_valid_early", 256'(tx_iq_valid), 256'(1'b0));
        wr_byte(8'hEF);
        chk("tx_q", 256'(tx_q), 256'(24'h123456));
        chk("tx_i", 256'(tx_i), 256'(24'hABCDEF));
        chk("tx_valid", 256'(tx_iq_valid), 256'(1'b1));
        chk("tx_idle", 256'(stage_debug), 256'(4'd0));
        tick();
        chk("tx_valid_end", 256'(tx_iq_valid), 256'(1'b0));

        // DATA_SYNC on the last TX byte slot suppresses the update.
        cmd(8'd3);
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44); wr_byte(8'h55);
        cmd(8'hFF);
        chk("txab_valid", 256'(tx_iq_valid), 256'(1'b0));
        chk("txab_iq", 256'({tx_q, tx_i}), 256'(48'h123456ABCDEF));
        chk("txab_idle", 256'({DATA_BUS_OE, stage_debug}), 256'(5'd0));

        // DATA_SYNC on the last parameter byte suppresses the copy.
        cmd(8'd1);
        for (int i = 0; i < 23; i++) wr_byte(8'h77);
        cmd(8'hFF);
        tick();
        chk("pwlast_upd", 256'(param_update), 256'(1'b0));
        chk("pwlast_regs", 256'(param_regs), 256'(p_first));

        // Enable both RX channels.
        cmd(8'd1);
        wr_byte(8'h03);
        for (int i = 0; i < 23; i++) wr_byte(8'h00);
        tick();
        chk("mask_regs", 256'(param_regs), 256'({8'h03, 184'h0}));
        chk("mask_rxen", 256'(rx_enable), 256'(2'b11));

        // RX stream, two channels.
        rx_q = {24'h000000, 24'h000001};
        rx_i = {24'h000000, 24'h000002};
        fr = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        cmd(8'd4);
        chk("rx_oe", 256'(DATA_BUS_OE), 256'(1'b1));
        chk("rx_rdreq0", 256'(iq_rd_req), 256'(1'b1));
        chk("rx_stage", 256'(stage_debug), 256'(4'd5));
        for (int k = 0; k < 14; k++) begin
            tick();
            chk($sformatf("rx_f1_b%0d", k), 256'(DATA_BUS), 256'(fr[k]));
            chk($sformatf("rx_f1_rd%0d", k), 256'(iq_rd_req), 256'(k == 13));
        end

        // Second frame built while the FIFO is empty.
        iq_empty = 1'b1;
        fr[0]  = 8'h02;
        fr[13] = 8'h01;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk($sformatf("rx_f2_b%0d", k), 256'(DATA_BUS), 256'(fr[k]));
            chk($sformatf("rx_f2_rd%0d", k), 256'(iq_rd_req), 256'(k == 13));
        end

        // Status readback with underrun set; status_in changes after the snapshot.
        cmd(8'd2);
        status_in = 96'h0;
        chk("st_oe", 256'(DATA_BUS_OE), 256'(1'b1));
        chk("st_stage", 256'(stage_debug), 256'(4'd3));
        tick();
        chk("st_b0", 256'(DATA_BUS), 256'(8'h03));
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("st_b%0d", k), 256'(DATA_BUS), 256'(8'hC0 + 8'(k - 1)));
        end
        tick();
        chk("st_end", 256'({DATA_BUS_OE, stage_debug}), 256'(5'd0));

        cmd(8'd2);
        tick();
        chk("st2_b0", 256'(DATA_BUS), 256'(8'h01));
        cmd(8'hFF);
        chk("st2_abort", 256'({DATA_BUS_OE, stage_debug}), 256'(5'd0));
        iq_empty = 1'b0;

        // Echo.
        cmd(8'd0);
        chk("echo_oe0", 256'({DATA_BUS_OE, stage_debug}), 256'(5'h01));
        wr_byte(8'hA5);
        chk("echo_oe1", 256'(DATA_BUS_OE), 256'(1'b1));
        chk("echo_b1", 256'(DATA_BUS), 256'(8'hA5));
        tick();
        chk("echo_oe2", 256'(DATA_BUS_OE), 256'(1'b0));
        wr_byte(8'h5A);
        chk("echo_oe3", 256'(DATA_BUS_OE), 256'(1'b1));
        chk("echo_b3", 256'(DATA_BUS), 256'(8'h5A));
        tick();
        chk("echo_oe4", 256'(DATA_BUS_OE), 256'(1'b0));

        // Async reset mid RX frame.
        cmd(8'd4);
        tick(); tick(); tick();
        chk("rr_oe_pre", 256'(DATA_BUS_OE), 256'(1'b1));
        #3;
        reset = 1'b1;
        #1;
        chk("rr_oe_async", 256'(DATA_BUS_OE), 256'(1'b0));
        chk("rr_stage_async", 256'(stage_debug), 256'(4'd0));
        tick();
        reset = 1'b0;
        chk("rr_params", 256'(param_regs), 256'(192'h0));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_idle%0d", k), 256'({DATA_BUS_OE, iq_rd_req, stage_debug}), 256'(6'd0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
